cic_interpolator: RTL

- Transmit-path CIC interpolating filter. It is the counterpart of the receive-side CIC decimator.
- Input side runs at the low rate: a single-entry holding register written by in_strobe. Low-rate path is STAGES comb stages.
- Output side runs at the high rate: zero-stuffing by RATE, then STAGES integrator stages, all enabled by the ce tick.
- Sits between the baseband sample source and the DAC/upconverter. Produces one out_data per ce tick.

---
 rtl/cic_pkg.sv | 28 ++
 rtl/cic_comb.sv | 28 ++
 rtl/cic_interpolator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared CIC helpers: clog2 and derived-width functions, used by both the
// interpolator and the decimator so their accumulator sizing stays identical.
package cic_pkg;

    // Ceiling log2 for elaboration-time width computation.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bit growth seen at the output of an N-stage CIC with factor 2**rate_log2,
    // after removing the R factor that zero-stuffing takes away.
    function automatic int cic_growth(input int stages, input int rate_log2);
        return (stages - 1) * rate_log2;
    endfunction

    // Accumulator width: input plus worst-case growth plus one bit per stage.
    function automatic int cic_acc_width(input int in_width, input int stages, input int growth);
        return in_width + stages + growth;
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage: diff = data_in - data_in(previous enable).
// The difference is combinational; only the delay register is clocked.
module cic_comb
    import cic_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] data_in,
    output logic signed [WIDTH-1:0] diff
);

    logic signed [WIDTH-1:0] delay;

    // Capture the current input as the next sample's reference.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delay <= '0;
        end else if (enable) begin
            delay <= data_in;
        end
    end

    assign diff = data_in - delay;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolating filter: single-entry input holding register, STAGES comb
// stages at the low rate, zero-stuffing by RATE, STAGES integrators at the
// high rate (ce). Optional macro CIC_INTERP_ROUND_EN selects round-half-up
// with saturation on the output instead of plain truncation.
//
// Input interface: in_strobe is a one-clock write pulse, not a stalling
// handshake. in_ready high means the holding register is empty and a write is
// accepted. A write while full is dropped and sets sticky overrun, except when
// it lands on the same clock as a phase-0 consume, which frees the entry.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int STAGES    = 3,
    parameter int RATE      = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        in_ready,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        underrun,
    output logic                        overrun
);

    localparam int RATE_LOG2 = clog2(RATE);
    localparam int GROWTH    = cic_growth(STAGES, RATE_LOG2);
    localparam int ACC_WIDTH = cic_acc_width(IN_WIDTH, STAGES, GROWTH);
    localparam int TOP_BIT   = IN_WIDTH + GROWTH - 1;

    logic [RATE_LOG2-1:0]          phase;
    logic                          hold_full;
    logic signed [IN_WIDTH-1:0]    hold_data;
    logic                          phase_zero;
    logic                          tick0;
    logic                          consume;
    logic signed [ACC_WIDTH-1:0]   comb_sig [STAGES+1];
    logic signed [ACC_WIDTH-1:0]   integ [STAGES];
    logic signed [ACC_WIDTH-1:0]   integ_next [STAGES];
    logic signed [OUT_WIDTH-1:0]   out_next;

    assign phase_zero = (phase == '0);
    assign tick0      = ce && phase_zero;
    assign consume    = tick0 && hold_full;
    assign in_ready   = !hold_full;

    // When empty, hold_data still equals the last consumed sample, so an
    // underrun tick naturally repeats it.
    assign comb_sig[0] = {{(ACC_WIDTH-IN_WIDTH){hold_data[IN_WIDTH-1]}}, hold_data};

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        cic_comb #(
            .WIDTH(ACC_WIDTH)
        ) u_comb (
            .clock  (clock),
            .reset  (reset),
            .enable (tick0),
            .data_in(comb_sig[k]),
            .diff   (comb_sig[k+1])
        );
    end

    // Holding register and sticky flags; a consume and a write on the same
    // clock leave the register full with the new sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (in_strobe && (!hold_full || consume)) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end
            if (in_strobe && hold_full && !consume) begin
                overrun <= 1'b1;
            end
            if (tick0 && !hold_full) begin
                underrun <= 1'b1;
            end
        end
    end

    // Integrator next values: zero-stuffed comb output feeds the first stage,
    // later stages accumulate the previous stage's old value.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            integ_next[k] = integ[k];
        end
        integ_next[0] = integ[0] + (phase_zero ? comb_sig[STAGES] : '0);
        for (int k = 1; k < STAGES; k++) begin
            integ_next[k] = integ[k] + integ[k-1];
        end
    end

`ifdef CIC_INTERP_ROUND_EN
    localparam int LSB_POS = TOP_BIT - OUT_WIDTH + 1;
    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'((1 << LSB_POS) >> 1);
    logic signed [ACC_WIDTH:0]       rounded;
    logic [ACC_WIDTH-TOP_BIT:0]      upper;

    // Round half up, then saturate when the result leaves the output range.
    always_comb begin
        rounded = {integ_next[STAGES-1][ACC_WIDTH-1], integ_next[STAGES-1]} + HALF;
        upper   = rounded[ACC_WIDTH:TOP_BIT];
        if (upper == '0 || upper == '1) begin
            out_next = rounded[TOP_BIT -: OUT_WIDTH];
        end else if (rounded[ACC_WIDTH]) begin
            out_next = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            out_next = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end
`else
    // Truncate: keep the OUT_WIDTH bits ending at the unity-gain MSB.
    always_comb begin
        out_next = integ_next[STAGES-1][TOP_BIT -: OUT_WIDTH];
    end
`endif

    // High-rate datapath: phase counter, integrators and output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            out_strobe <= 1'b0;
            out_data   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
            end
        end else begin
            out_strobe <= ce;
            if (ce) begin
                phase    <= phase + 1'b1;
                out_data <= out_next;
                for (int k = 0; k < STAGES; k++) begin
                    integ[k] <= integ_next[k];
                end
            end
        end
    end

endmodule
